apb_arb_master: RTL and testbench
=================================

APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 SHALL have parameter DATA_W, default 32, APB data width.
REQ-002 SHALL have parameter ADDR_W, default 4, APB address width.
REQ-003 SHALL have parameter N_REQ, default 2, number of requester ports, range 2..8.
REQ-004 SHALL have parameter TIMEOUT, default 16, max ACCESS cycles before abort, range 2..255.
REQ-005 SHALL have port PCLK, input, 1, rising-edge clock.
REQ-006 SHALL have port PRESETn, input, 1: reset PRESETn, asynchronous, active-low.
REQ-007 SHALL have port req_valid, input, N_REQ, per-requester command pending.
REQ-008 SHALL have port req_write, input, N_REQ, per-requester 1=write 0=read.
REQ-009 SHALL have port req_addr, input, N_REQ*ADDR_W, packed addresses, requester i at slice i.
REQ-010 SHALL have port req_wdata, input, N_REQ*DATA_W, packed write data.
REQ-011 SHALL have port req_ready, output, N_REQ, one-hot command-accept pulse.
REQ-012 SHALL have port rsp_valid, output, N_REQ, one-hot completion pulse.
REQ-013 SHALL have port rsp_rdata, output, DATA_W, read data, valid with rsp_valid.
REQ-014 SHALL have port rsp_err, output, 1, timeout flag, valid with rsp_valid.
REQ-015 SHALL have ports PSEL, PENABLE, PWRITE (output, 1), PADDR (output, ADDR_W), PWDATA (output, DATA_W): APB master side.
REQ-016 SHALL have ports PRDATA (input, DATA_W) and PREADY (input, 1): APB slave response.

Function
REQ-017 SHALL implement states IDLE, SETUP, ACCESS; all outputs registered.
REQ-018 IDLE with any req_valid: grant the first set req_valid at or after rr_ptr (wrapping N_REQ-1 -> 0), pulse req_ready[g] one cycle, latch write/addr/wdata of g, go to SETUP.
REQ-019 rr_ptr SHALL update to (g+1) mod N_REQ only on a grant; no change while idle.
REQ-020 SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA = latched command; next state ACCESS unconditionally.
REQ-021 ACCESS: PSEL=1, PENABLE=1, command unchanged; wait counter increments each ACCESS cycle.
REQ-022 ACCESS with PREADY=1: pulse rsp_valid[g] next cycle, rsp_rdata = PRDATA for reads, 0 for writes, rsp_err=0, drop PSEL/PENABLE, go to IDLE.
REQ-023 ACCESS with wait counter reaching TIMEOUT-1 and PREADY=0: pulse rsp_valid[g] with rsp_err=1, rsp_rdata=0, drop PSEL/PENABLE, go to IDLE.
REQ-024 PREADY and timeout in the same cycle: PREADY wins, rsp_err=0.
REQ-025 Minimum transfer: grant-to-rsp_valid latency 3 cycles; at least one IDLE cycle between transfers.
REQ-026 Requesters SHALL hold req_* stable while req_valid until req_ready; req_valid dropped before grant is ignored, no response.
REQ-027 PREADY, PRDATA SHALL be ignored outside ACCESS.
REQ-028 rsp_rdata, rsp_err SHALL hold last value between rsp_valid pulses.

Reset
REQ-029 PRESETn low SHALL force state IDLE, rr_ptr 0, wait counter 0, all outputs 0, asynchronously.
REQ-030 Reset mid-transfer SHALL abort it with no rsp_valid; the request is not retried.
REQ-031 First grant after reset deassertion SHALL occur no earlier than the second PCLK edge.

Structure
REQ-032 Package apb_arb_pkg SHALL hold the state enum, default widths and TIMEOUT default.
REQ-033 Grant logic SHALL be sub-module rr_arbiter (req vector + pointer -> one-hot grant, index).

Verification
REQ-034 Single write: req0 write addr 0x3 data 0xA5A5_0001, PREADY=1 in ACCESS -> PSEL 2 cycles, PENABLE 1 cycle, rsp_valid[0] 3 cycles after req_ready, rsp_err=0.
REQ-035 Read-back: req1 read addr 0x3, PRDATA=0xA5A5_0001 with PREADY -> rsp_valid[1], rsp_rdata=0xA5A5_0001.
REQ-036 Contention: req0 and req1 held valid for 4 commands after reset -> grants 0,1,0,1.
REQ-037 Wait states: PREADY low 5 ACCESS cycles then high -> no error, PSEL held 7 cycles, command stable throughout.
REQ-038 Timeout: PREADY held 0, TIMEOUT=16 -> rsp_err=1, rsp_rdata=0 after 16 ACCESS cycles, state IDLE.
REQ-039 Reset in ACCESS: PRESETn low -> PSEL/PENABLE 0 immediately, no rsp_valid, rr_ptr 0 after release.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and default sizing for the round-robin APB master.
package apb_arb_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 4;
    localparam int N_REQ_DEF   = 2;
    localparam int TIMEOUT_DEF = 16;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

endpackage

// File: rtl/apb_arb_master_if.sv
// APB bus bundle between the arbitrating master and a slave.
interface apb_arb_master_if
    import apb_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );

endinterface

// File: rtl/apb_arb_master_rr_arbiter.sv
// Round-robin grant: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] jj;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        jj  = '0;
        for (int k = 0; k < N; k++) begin
            jj = IW'((int'(ptr) + k) % N);
            if (!any && req[jj]) begin
                any     = 1'b1;
                gnt[jj] = 1'b1;
                idx     = jj;
            end
        end
    end

endmodule

// File: rtl/apb_arb_master.sv
// N-requester round-robin APB master with wait-state timeout.
module apb_arb_master
    import apb_arb_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int N_REQ   = N_REQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_write,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    apb_arb_master_if.master        apb
);

    localparam int IW = $clog2(N_REQ);

    state_t state, state_n;

    logic [IW-1:0]    rr_ptr, ptr_n;
    logic [IW-1:0]    cur, cur_n;
    logic             started;
    logic [CNT_W-1:0] wait_cnt, cnt_n;

    logic [N_REQ-1:0] gnt, ready_n;
    logic [IW-1:0]    gidx;
    logic             gany;

    logic              wr_q, wr_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic              psel_q, psel_n;
    logic              pen_q, pen_n;

    logic              done_n, err_n;
    logic [DATA_W-1:0] data_n;
    logic              done_q, done_err;
    logic [DATA_W-1:0] done_data;
    logic [IW-1:0]     done_idx;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gidx),
        .any (gany)
    );

    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = pen_q;
    assign apb.PWRITE  = wr_q;
    assign apb.PADDR   = addr_q;
    assign apb.PWDATA  = wdata_q;

    always_comb begin
        state_n = state;
        ptr_n   = rr_ptr;
        cur_n   = cur;
        cnt_n   = wait_cnt;
        wr_n    = wr_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        ready_n = '0;
        psel_n  = 1'b0;
        pen_n   = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        data_n  = '0;
        unique case (state)
            IDLE: begin
                // started keeps the first edge after reset grant-free
                if (started && gany) begin
                    state_n = SETUP;
                    ready_n = gnt;
                    cur_n   = gidx;
                    ptr_n   = (gidx == IW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
                    wr_n    = req_write[gidx];
                    addr_n  = req_addr[gidx*ADDR_W +: ADDR_W];
                    wdata_n = req_wdata[gidx*DATA_W +: DATA_W];
                    psel_n  = 1'b1;
                end
            end
            SETUP: begin
                state_n = ACCESS;
                cnt_n   = '0;
                psel_n  = 1'b1;
                pen_n   = 1'b1;
            end
            ACCESS: begin
                if (apb.PREADY) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    data_n  = wr_q ? '0 : apb.PRDATA;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    err_n   = 1'b1;
                end else begin
                    cnt_n  = wait_cnt + 1'b1;
                    psel_n = 1'b1;
                    pen_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cur       <= '0;
            started   <= 1'b0;
            wait_cnt  <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            psel_q    <= 1'b0;
            pen_q     <= 1'b0;
            req_ready <= '0;
        end else begin
            state     <= state_n;
            rr_ptr    <= ptr_n;
            cur       <= cur_n;
            started   <= 1'b1;
            wait_cnt  <= cnt_n;
            wr_q      <= wr_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            psel_q    <= psel_n;
            pen_q     <= pen_n;
            req_ready <= ready_n;
        end
    end

    // completion is staged once so rsp_valid lands three cycles after req_ready
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            done_q    <= 1'b0;
            done_err  <= 1'b0;
            done_data <= '0;
            done_idx  <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            done_q <= done_n;
            if (done_n) begin
                done_err  <= err_n;
                done_data <= data_n;
                done_idx  <= cur;
            end
            rsp_valid <= done_q ? (N_REQ'(1) << done_idx) : '0;
            if (done_q) begin
                rsp_rdata <= done_data;
                rsp_err   <= done_err;
            end
        end
    end

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed checks of apb_arb_master: grants, APB phases, wait states, timeout, reset.
module tb_apb_arb_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;
    int n;
    int pen;
    logic stable;

    apb_arb_master_if #(.DATA_W(32), .ADDR_W(4)) bus ();

    apb_arb_master #(
        .DATA_W(32), .ADDR_W(4), .N_REQ(2), .TIMEOUT(16)
    ) dut (
        .PCLK      (clk),
        .PRESETn   (rst_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .apb       (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input string tag, input logic [1:0] exp);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (req_ready == 2'b00 && k < 10);
        chk(tag, req_ready, exp);
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = '0;
        req_write   = '0;
        req_addr    = '0;
        req_wdata   = '0;
        bus.PREADY  = 1'b0;
        bus.PRDATA  = '0;
        step();
        step();
        chk("rst_psel", bus.PSEL, 1'b0);
        chk("rst_penable", bus.PENABLE, 1'b0);
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_err", rsp_err, 1'b0);

        // single write from req0, PREADY high everywhere
        rst_n      = 1'b1;
        req_valid  = 2'b01;
        req_write  = 2'b01;
        req_addr   = 8'h03;
        req_wdata  = 64'h0000_0000_A5A5_0001;
        bus.PREADY = 1'b1;
        step();
        chk("no_grant_first_edge", req_ready, 2'b00);
        step();
        chk("wr_ready", req_ready, 2'b01);
        chk("wr_setup_psel", bus.PSEL, 1'b1);
        chk("wr_setup_penable", bus.PENABLE, 1'b0);
        chk("wr_paddr", bus.PADDR, 4'h3);
        chk("wr_pwrite", bus.PWRITE, 1'b1);
        chk("wr_pwdata", bus.PWDATA, 32'hA5A5_0001);
        req_valid = 2'b00;
        step();
        chk("wr_access_psel", bus.PSEL, 1'b1);
        chk("wr_access_penable", bus.PENABLE, 1'b1);
        chk("wr_ready_pulse", req_ready, 2'b00);
        step();
        chk("wr_psel_drop", bus.PSEL, 1'b0);
        chk("wr_rsp_early", rsp_valid, 2'b00);
        step();
        chk("wr_rsp_valid", rsp_valid, 2'b01);
        chk("wr_rsp_err", rsp_err, 1'b0);
        chk("wr_rsp_rdata", rsp_rdata, 32'h0);
        step();
        chk("wr_rsp_pulse", rsp_valid, 2'b00);

        // read-back from req1
        req_valid  = 2'b10;
        req_write  = 2'b00;
        req_addr   = 8'h30;
        bus.PRDATA = 32'hA5A5_0001;
        step();
        chk("rd_ready", req_ready, 2'b10);
        chk("rd_pwrite", bus.PWRITE, 1'b0);
        chk("rd_paddr", bus.PADDR, 4'h3);
        req_valid = 2'b00;
        step();
        step();
        step();
        chk("rd_rsp_valid", rsp_valid, 2'b10);
        chk("rd_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
        chk("rd_rsp_err", rsp_err, 1'b0);
        bus.PRDATA = 32'h0;
        step();
        chk("rd_rdata_hold", rsp_rdata, 32'hA5A5_0001);

        // contention: both requesters held valid
        req_valid = 2'b11;
        req_write = 2'b11;
        req_addr  = 8'h21;
        req_wdata = 64'h2222_2222_1111_1111;
        wait_grant("cont_g0", 2'b01);
        wait_grant("cont_g1", 2'b10);
        wait_grant("cont_g2", 2'b01);
        wait_grant("cont_g3", 2'b10);
        req_valid = 2'b00;
        step();
        step();
        step();
        chk("cont_last_rsp", rsp_valid, 2'b10);

        // five wait states then PREADY
        req_valid = 2'b01;
        req_write = 2'b01;
        req_addr  = 8'h05;
        req_wdata = 64'h0000_0000_1234_5678;
        wait_grant("ws_ready", 2'b01);
        req_valid  = 2'b00;
        bus.PREADY = 1'b0;
        n = 0;
        stable = 1'b1;
        while (bus.PSEL === 1'b1 && n < 40) begin
            n++;
            if (bus.PADDR !== 4'h5 || bus.PWDATA !== 32'h1234_5678 ||
                bus.PWRITE !== 1'b1)
                stable = 1'b0;
            if (n == 7)
                bus.PREADY = 1'b1;
            step();
        end
        chk("ws_psel_cycles", n, 7);
        chk("ws_cmd_stable", stable, 1'b1);
        step();
        chk("ws_rsp_valid", rsp_valid, 2'b01);
        chk("ws_rsp_err", rsp_err, 1'b0);

        // timeout on a read from req1
        req_valid  = 2'b10;
        req_write  = 2'b00;
        req_addr   = 8'h70;
        bus.PRDATA = 32'hDEAD_BEEF;
        wait_grant("to_ready", 2'b10);
        req_valid  = 2'b00;
        bus.PREADY = 1'b0;
        n = 0;
        pen = 0;
        while (bus.PSEL === 1'b1 && n < 60) begin
            n++;
            if (bus.PENABLE === 1'b1)
                pen++;
            step();
        end
        chk("to_psel_cycles", n, 17);
        chk("to_access_cycles", pen, 16);
        step();
        chk("to_rsp_valid", rsp_valid, 2'b10);
        chk("to_rsp_err", rsp_err, 1'b1);
        chk("to_rsp_rdata", rsp_rdata, 32'h0);
        step();
        chk("to_rsp_pulse", rsp_valid, 2'b00);
        chk("to_err_hold", rsp_err, 1'b1);
        chk("to_idle_psel", bus.PSEL, 1'b0);

        // reset during ACCESS
        req_valid = 2'b01;
        req_write = 2'b01;
        req_addr  = 8'h09;
        req_wdata = 64'h0000_0000_0000_0055;
        wait_grant("rst_mid_ready", 2'b01);
        req_valid = 2'b00;
        step();
        step();
        chk("rst_mid_in_access", bus.PENABLE, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_psel", bus.PSEL, 1'b0);
        chk("rst_mid_penable", bus.PENABLE, 1'b0);
        chk("rst_mid_err", rsp_err, 1'b0);
        step();
        step();
        chk("rst_mid_no_rsp", rsp_valid, 2'b00);
        rst_n     = 1'b1;
        req_valid = 2'b11;
        step();
        chk("rst_rel_no_grant", req_ready, 2'b00);
        chk("rst_rel_no_rsp", rsp_valid, 2'b00);
        step();
        chk("rst_rel_ptr0", req_ready, 2'b01);
        req_valid  = 2'b00;
        bus.PREADY = 1'b1;
        step();
        step();
        step();
        chk("rst_rel_rsp", rsp_valid, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
